// File: rtl/bitstream_expander.sv
// Queues per-cycle encoder bitstream groups as compact descriptors and expands
// them (including run-length repeats) into an in-order valid/ready byte stream.
module bitstream_expander #(
    parameter int BITSTREAM_WIDTH = 8,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       top_clk,
    input  logic                       top_reset,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_1,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_2,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_3,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_4,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_1_5,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_1,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_2,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_3,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_4,
    input  logic [BITSTREAM_WIDTH-1:0] in_bit_2_5,
    input  logic [2:0]                 in_flag_1,
    input  logic [2:0]                 in_flag_2,
    input  logic                       in_flag_last,
    output logic [BITSTREAM_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_end,
    output logic                       overflow,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);
    localparam int W = BITSTREAM_WIDTH;
    localparam int A = FIFO_ADDR_WIDTH;
    localparam logic [A:0] FULL = (A+1)'(2**A);

    typedef struct packed {
        logic         last;
        logic [2:0]   flag;
        logic [W-1:0] b1;
        logic [W-1:0] b2;
        logic [W-1:0] b3;
        logic [W-1:0] b4;
        logic [W-1:0] b5;
    } entry_t;

    typedef enum logic [2:0] {IDLE, HEAD, BODY, RUN, TAIL4, TAIL5, END} state_t;

    entry_t       grp1, grp2, slot0_d, slot1_d, slot0, slot1, head;
    logic         use1, use2;
    logic [1:0]   n_d, stage_n;
    entry_t       mem [2**A];
    logic [A-1:0] wr_ptr, rd_ptr;
    logic [A:0]   post_pop, n_ext;
    logic         push_ok, pop, fifo_empty, accept, final_byte;
    state_t       state;
    logic         cur_last;
    logic [2:0]   cur_flag;
    logic [W-1:0] cur_b2, cur_b3, cur_b4, cur_b5, cnt;

    // Pack the cycle's groups in order; the last marker rides on the final entry.
    always_comb begin
        use1 = (in_flag_1 != 3'd0) && (in_flag_1 != 3'd4);
        use2 = (in_flag_2 != 3'd0) && (in_flag_2 != 3'd4);
        grp1 = {1'b0, in_flag_1, in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5};
        grp2 = {1'b0, in_flag_2, in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5};
        slot0_d = '0;
        slot1_d = '0;
        n_d     = 2'd0;
        if (use1 && use2) begin
            slot0_d      = grp1;
            slot1_d      = grp2;
            slot1_d.last = in_flag_last;
            n_d          = 2'd2;
        end else if (use1) begin
            slot0_d      = grp1;
            slot0_d.last = in_flag_last;
            n_d          = 2'd1;
        end else if (use2) begin
            slot0_d      = grp2;
            slot0_d.last = in_flag_last;
            n_d          = 2'd1;
        end else if (in_flag_last) begin
            slot0_d.last = 1'b1;
            slot0_d.flag = 3'd4;
            n_d          = 2'd1;
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            stage_n <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
        end else begin
            stage_n <= n_d;
            slot0   <= slot0_d;
            slot1   <= slot1_d;
        end
    end

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_level == '0);

    always_comb begin
        n_ext    = (A+1)'(stage_n);
        post_pop = fifo_level - (A+1)'(pop);
        push_ok  = (stage_n != 2'd0) && (n_ext <= (FULL - post_pop));
    end

    always_ff @(posedge top_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= slot0;
            if (stage_n == 2'd2) mem[wr_ptr + A'(1)] <= slot1;
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + A'(1);
            if (push_ok) wr_ptr <= wr_ptr + A'(stage_n);
            else if (stage_n != 2'd0) overflow <= 1'b1;
            fifo_level <= post_pop + (push_ok ? n_ext : '0);
        end
    end

    // A new entry is loaded in the same cycle the previous final byte is taken.
    always_comb begin
        final_byte = 1'b0;
        case (state)
            HEAD:    final_byte = (cur_flag == 3'd1) || ((cur_flag == 3'd5) && (cur_b3 == '0));
            BODY:    final_byte = (cnt == '0);
            RUN:     final_byte = (cnt == W'(1)) && (cur_flag == 3'd5);
            TAIL4:   final_byte = (cur_flag == 3'd6);
            TAIL5:   final_byte = 1'b1;
            default: final_byte = 1'b0;
        endcase
        accept = out_valid && out_ready;
        pop    = !fifo_empty &&
                 ((state == IDLE) || (state == END) || (accept && final_byte && !cur_last));
    end

    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            state     <= IDLE;
            cur_last  <= 1'b0;
            cur_flag  <= '0;
            cur_b2    <= '0;
            cur_b3    <= '0;
            cur_b4    <= '0;
            cur_b5    <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_end   <= 1'b0;
        end else begin
            out_end <= 1'b0;
            if (pop) begin
                cur_last <= head.last;
                cur_flag <= head.flag;
                cur_b2   <= head.b2;
                cur_b3   <= head.b3;
                cur_b4   <= head.b4;
                cur_b5   <= head.b5;
                if (head.flag == 3'd4) begin
                    state     <= END;
                    out_end   <= 1'b1;
                    out_valid <= 1'b0;
                end else begin
                    state     <= HEAD;
                    out_data  <= head.b1;
                    out_valid <= 1'b1;
                end
            end else if ((state == IDLE) || (state == END)) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else if (accept) begin
                if (final_byte) begin
                    out_valid <= 1'b0;
                    if (cur_last) begin
                        state   <= END;
                        out_end <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    case (state)
                        HEAD: begin
                            if (!cur_flag[2]) begin
                                state    <= BODY;
                                out_data <= cur_b2;
                                cnt      <= (cur_flag == 3'd3) ? W'(1) : '0;
                            end else if (cur_b3 != '0) begin
                                state    <= RUN;
                                out_data <= cur_b2;
                                cnt      <= cur_b3;
                            end else begin
                                state    <= TAIL4;
                                out_data <= cur_b4;
                            end
                        end
                        BODY: begin
                            out_data <= cur_b3;
                            cnt      <= '0;
                        end
                        RUN: begin
                            if (cnt != W'(1)) begin
                                cnt <= cnt - W'(1);
                            end else begin
                                state    <= TAIL4;
                                out_data <= cur_b4;
                            end
                        end
                        TAIL4: begin
                            state    <= TAIL5;
                            out_data <= cur_b5;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bitstream_expander.sv
// Directed and randomised checks of bitstream_expander against a queue-based
// model of the flag expansion rules.
module tb_bitstream_expander;
    logic       top_clk = 1'b0;
    logic       top_reset = 1'b1;
    logic [7:0] in_bit_1_1 = '0, in_bit_1_2 = '0, in_bit_1_3 = '0, in_bit_1_4 = '0, in_bit_1_5 = '0;
    logic [7:0] in_bit_2_1 = '0, in_bit_2_2 = '0, in_bit_2_3 = '0, in_bit_2_4 = '0, in_bit_2_5 = '0;
    logic [2:0] in_flag_1 = '0, in_flag_2 = '0;
    logic       in_flag_last = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_end;
    logic       overflow;
    logic [4:0] fifo_level;

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   model_bytes = 0;
    int   end_seen = 0;
    bit   rnd_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    localparam int END_TOKEN = 256;

    bitstream_expander #(
        .BITSTREAM_WIDTH(8),
        .FIFO_ADDR_WIDTH(4)
    ) dut (
        .top_clk(top_clk), .top_reset(top_reset),
        .in_bit_1_1(in_bit_1_1), .in_bit_1_2(in_bit_1_2), .in_bit_1_3(in_bit_1_3),
        .in_bit_1_4(in_bit_1_4), .in_bit_1_5(in_bit_1_5),
        .in_bit_2_1(in_bit_2_1), .in_bit_2_2(in_bit_2_2), .in_bit_2_3(in_bit_2_3),
        .in_bit_2_4(in_bit_2_4), .in_bit_2_5(in_bit_2_5),
        .in_flag_1(in_flag_1), .in_flag_2(in_flag_2), .in_flag_last(in_flag_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_end(out_end), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 top_clk = ~top_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input int v);
        exp_q.push_back(v);
        if (v != END_TOKEN) model_bytes++;
    endfunction

    // Byte list a single group produces, straight from the flag rules.
    function automatic void model(input logic [2:0] f, input logic [39:0] g);
        int b [5];
        for (int i = 0; i < 5; i++) b[i] = int'(g[39 - 8*i -: 8]);
        if (f >= 3'd1 && f <= 3'd3) begin
            for (int i = 0; i < int'(f); i++) push_exp(b[i]);
        end else if (f >= 3'd5) begin
            push_exp(b[0]);
            for (int r = 0; r < b[2]; r++) push_exp(b[1]);
            if (f >= 3'd6) push_exp(b[3]);
            if (f == 3'd7) push_exp(b[4]);
        end
    endfunction

    function automatic int next_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    // Observed stream: accepted bytes and end pulses, in order.
    always @(negedge top_clk) begin
        if (top_reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_end) begin
                end_seen++;
                check("end_with_valid", 32'(out_valid), 32'd0);
                check("stream_end", 32'(END_TOKEN), 32'(next_exp()));
            end
            if (out_valid && out_ready) check("stream_byte", 32'(out_data), 32'(next_exp()));
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic step();
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(posedge top_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f1, input logic [39:0] g1,
                         input logic [2:0] f2, input logic [39:0] g2,
                         input logic last, input bit keep);
        {in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5} = g1;
        {in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5} = g2;
        in_flag_1    = f1;
        in_flag_2    = f2;
        in_flag_last = last;
        if (keep) begin
            model(f1, g1);
            model(f2, g2);
            if (last) push_exp(END_TOKEN);
        end
        step();
        in_flag_1    = 3'd0;
        in_flag_2    = 3'd0;
        in_flag_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_end"}, 32'(out_end), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        logic [7:0] seq2 [7];
        int         e0;

        repeat (2) @(posedge top_clk);
        #1;
        check_reset_values("reset");
        top_reset = 1'b0;
        step();

        // Flag 3 latency and back-to-back bytes.
        drive(3'd3, 40'h11_22_33_00_00, 3'd0, 40'h0, 1'b0, 1'b1);
        check("lat_k_valid", 32'(out_valid), 32'd0);
        step();
        check("lat_k1_valid", 32'(out_valid), 32'd0);
        check("lat_k1_level", 32'(fifo_level), 32'd1);
        step();
        check("lat_k2_valid", 32'(out_valid), 32'd1);
        check("lat_k2_data", 32'(out_data), 32'h11);
        check("lat_k2_level", 32'(fifo_level), 32'd0);
        step();
        check("f3_b2", 32'(out_data), 32'h22);
        step();
        check("f3_b3", 32'(out_data), 32'h33);
        step();
        check("f3_done_valid", 32'(out_valid), 32'd0);

        // Two groups in one cycle, gapless expansion including a run.
        seq2 = '{8'hA0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};
        drive(3'd1, 40'hA0_00_00_00_00, 3'd7, 40'h40_FF_03_01_02, 1'b0, 1'b1);
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            check("pair_valid", 32'(out_valid), 32'd1);
            check("pair_data", 32'(out_data), 32'(seq2[i]));
            step();
        end
        check("pair_done_valid", 32'(out_valid), 32'd0);

        // Zero-length runs, then an ignored flag 4.
        drive(3'd5, 40'h51_52_00_54_55, 3'd6, 40'h61_62_00_64_65, 1'b0, 1'b1);
        drain("zero_run");
        drive(3'd4, 40'h41_42_43_44_45, 3'd0, 40'h0, 1'b0, 1'b1);
        step();
        check("flag4_level", 32'(fifo_level), 32'd0);
        step();
        check("flag4_level2", 32'(fifo_level), 32'd0);
        check("flag4_valid", 32'(out_valid), 32'd0);

        // End marker with no entries follows the earlier bytes.
        rnd_ready = 1'b1;
        e0 = end_seen;
        drive(3'd3, 40'h31_32_33_00_00, 3'd0, 40'h0, 1'b0, 1'b1);
        drive(3'd0, 40'h0, 3'd0, 40'h0, 1'b1, 1'b1);
        drain("marker");
        check("marker_end_once", 32'(end_seen - e0), 32'd1);

        // Randomised mix with a 255-long run and random back-pressure.
        begin
            int  start = model_bytes;
            int  it = 0;
            bit  big_done = 1'b0;
            logic [2:0]  f1, f2;
            logic [39:0] g1, g2;
            while ((model_bytes - start) < 300 && it < 4000) begin
                it++;
                if (fifo_level > 5'd10) begin
                    step();
                    continue;
                end
                f1 = 3'($urandom_range(0, 7));
                f2 = 3'($urandom_range(0, 7));
                g1 = {8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom)};
                g2 = {8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom)};
                if (!big_done && it >= 3) begin
                    f1       = 3'd7;
                    g1[23:16] = 8'd255;
                    big_done = 1'b1;
                end
                drive(f1, g1, f2, g2, ($urandom_range(0, 7) == 0), 1'b1);
                if ($urandom_range(0, 1) == 0) step();
            end
            drain("random");
            check("random_overflow", 32'(overflow), 32'd0);
        end

        // Overflow: sink stalled on one entry, then two entries per cycle.
        rnd_ready = 1'b0;
        out_ready = 1'b0;
        drive(3'd1, 40'hC0_00_00_00_00, 3'd0, 40'h0, 1'b0, 1'b1);
        step();
        step();
        check("ovf_hold_valid", 32'(out_valid), 32'd1);
        check("ovf_hold_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 9; i++)
            drive(3'd1, {8'(8'h10 + 2*i), 32'h0}, 3'd1, {8'(8'h11 + 2*i), 32'h0}, 1'b0, (i < 8));
        check("ovf_level_full", 32'(fifo_level), 32'd16);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        step();
        check("ovf_level_kept", 32'(fifo_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_hold_data", 32'(out_data), 32'hC0);
        out_ready = 1'b1;
        drain("overflow");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during a long run discards everything pending.
        drive(3'd5, 40'h55_66_C8_00_00, 3'd0, 40'h0, 1'b0, 1'b1);
        drive(3'd1, 40'h77_00_00_00_00, 3'd0, 40'h0, 1'b0, 1'b1);
        repeat (6) step();
        check("midrun_valid", 32'(out_valid), 32'd1);
        check("midrun_data", 32'(out_data), 32'h66);
        top_reset = 1'b1;
        exp_q.delete();
        step();
        check_reset_values("midrun_reset");
        top_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_reset_quiet", 32'(out_valid), 32'd0);
        end
        drive(3'd2, 40'h81_82_00_00_00, 3'd0, 40'h0, 1'b1, 1'b1);
        drain("post_reset");

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitstream_expander.md
# bitstream_expander

Downstream stage of `entropy_encoder`. It consumes the two per-cycle bitstream groups (`OUT_BIT_x_1..5`, `OUT_FLAG_BITSTREAM_x`) and the `OUT_FLAG_LAST` marker, and queues them as compact descriptors in a FIFO. The descriptors are expanded, including run-length carry runs, into an in-order byte stream on a valid/ready interface. The encoder has no stall input, so the block absorbs bursts in the FIFO and flags any loss.

## Interface
- `BITSTREAM_WIDTH`, 8, byte width; matches the encoder's `TOP_BITSTREAM_WIDTH`.
- `FIFO_ADDR_WIDTH`, 4, descriptor FIFO depth is 2^N (16 entries).
- `top_clk` in 1: the single clock.
- `top_reset` in 1: synchronous, active-high reset.
- `in_bit_1_1`..`in_bit_1_5` in `BITSTREAM_WIDTH` each: group 1 bytes b1..b5.
- `in_bit_2_1`..`in_bit_2_5` in `BITSTREAM_WIDTH` each: group 2 bytes b1..b5.
- `in_flag_1`, `in_flag_2` in 3 each: group descriptor flags.
- `in_flag_last` in 1: end-of-frame marker.
- `out_data` out `BITSTREAM_WIDTH`: output byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the sink accepts the byte.
- `out_end` out 1: one-cycle pulse marking the frame end.
- `overflow` out 1: sticky; input was dropped.
- `fifo_level` out `FIFO_ADDR_WIDTH+1`: number of occupied descriptor entries.

## Operation
- Flag semantics per group, applied in order:
  - 0: no bytes.
  - 1..3: emit b1..b_flag.
  - 4: no bytes (ignored).
  - 5: b1, then b2 repeated b3 times (b3 = 0 gives no repeats).
  - 6: as 5, then b4.
  - 7: as 6, then b5.
- Descriptor entry is {last, flag[2:0], b1..b5}.
- Each input cycle creates one entry per group whose flag is neither 0 nor 4. Group 1's entry precedes group 2's.
- `last` is set on the final entry created that cycle.
- If `in_flag_last` = 1 and no entry is created, one marker entry {last=1, flag=4} is created.
- Each cycle writes 0, 1 or 2 entries. This is all-or-nothing: if free space is less than the entries needed, every entry from that cycle is dropped and `overflow` is set to 1 until reset.
- Expander FSM states: IDLE, HEAD (b1), BODY (b2/b3 for flags 1..3), RUN (b2 with a down-counter loaded from b3), TAIL4, TAIL5, END.
  - Flags 1..3: HEAD, then BODY for the remaining bytes.
  - Flags 5..7: HEAD, then RUN (skipped when b3 = 0), then TAIL4 if flag ≥ 6, then TAIL5 if flag = 7.
  - Marker entry: goes straight to END.
  - After finishing any entry with last = 1: END for exactly one cycle. END asserts `out_end`, consumes no handshake, then the FSM goes to IDLE or the next entry.
- An entry is popped when the FSM loads it. The FSM loads the next entry in the same cycle the previous entry's final byte is accepted, so there is no bubble between entries.
- `out_data` and `out_valid` stay stable until `out_ready` is high, standard valid/ready.

## Timing
- Reset (synchronous): FIFO emptied, FSM to IDLE, `out_valid`=0, `out_data`=0, `out_end`=0, `overflow`=0, `fifo_level`=0. A reset mid-expansion discards all pending bytes.
- Latency: inputs sampled at edge k, with the FIFO empty and the FSM idle, give the first byte valid after edge k+2.
- Throughput: 1 byte per cycle while `out_ready`=1.
- Simultaneous push and pop: `fifo_level` changes by pushes − pops. A full FIFO with one pop in the same cycle frees space for this cycle's write: the free-space check uses the post-pop count.
- Pointers wrap modulo 2^`FIFO_ADDR_WIDTH`. `fifo_level` saturates at 2^`FIFO_ADDR_WIDTH` and never exceeds it.
- The RUN counter is 8 bits; b3 = 255 gives 255 repeats.
- `out_end` never coincides with `out_valid` from the same entry. It follows the acceptance of that entry's last byte by exactly 1 cycle.

## Test plan
- Group 1 flag 3, bytes 0x11/0x22/0x33, `out_ready`=1 → `out_data` is 0x11, 0x22, 0x33 on three consecutive cycles, first valid at edge k+2.
- Same cycle: group 1 flag 1 (b1=0xA0); group 2 flag 7 (b1=0x40, b2=0xFF, b3=3, b4=0x01, b5=0x02) → A0, 40, FF, FF, FF, 01, 02 with no gaps.
- Flag 5 with b3=0 → b1 only. Flag 6 with b3=0 → b1 then b4. Flag 4 → no bytes and no entry (`fifo_level` unchanged).
- Randomised `out_ready` over a 300-byte mix including b3=255 → the byte sequence matches the flag semantics, and `out_data` is held stable while stalled.
- `out_ready`=0, two entries per cycle for 9 cycles (depth 16) → `fifo_level`=16 after 8 cycles; the 9th cycle is dropped whole, `overflow`=1; the first 16 entries drain correctly.
- `in_flag_last`=1 with both flags 0 → `out_end` pulses once, after all earlier bytes are accepted. Reset asserted mid-RUN → outputs reach their reset values on the next edge and no stale bytes appear afterwards.
